// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: MMIO window constants, read-select encoding and byte-lane merge helper
package data_sram_responder_pkg;
  localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;
  localparam logic [15:0] OFS_LED     = 16'hF000;
  localparam logic [15:0] OFS_NUM     = 16'hF010;
  localparam logic [15:0] OFS_SW      = 16'hF020;
  localparam logic [15:0] OFS_TIMER   = 16'hE000;
  localparam logic [15:0] OFS_TCMP    = 16'hE004;
  localparam logic [15:0] OFS_TCTRL   = 16'hE008;
  localparam int          TCTRL_EN    = 0;
  localparam int          TCTRL_PEND  = 1;
  typedef enum logic {SEL_RAM, SEL_MMIO} rsel_e;
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] wen);
    for (int i = 0; i < 4; i++) lane_merge[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/data_sram_responder_bram_be.sv
// data_sram_responder_bram_be: single-port byte-writable sync RAM with registered read-old-data
module data_sram_responder_bram_be #(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**RAM_AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data_sram port responder with byte-writable RAM and LED/NUM/SWITCH/timer MMIO
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out,
  output logic        timer_irq
);
  logic [15:0] led, ofs;
  logic [31:0] num, timer, tcmp, mmio_rd, mmio_q, ram_q;
  logic        t_en, pend, is_mmio, wr, rd, mwr, tctrl_wr, set_pend;
  rsel_e       sel_q;
  logic        unused_addr;
  assign unused_addr = ^data_sram_addr[1:0];
  assign ofs      = data_sram_addr[15:0];
  assign is_mmio  = data_sram_addr[31:16] == MMIO_HI;
  assign wr       = data_sram_en && |data_sram_wen;
  assign rd       = data_sram_en && data_sram_wen == 4'b0;
  assign mwr      = wr && is_mmio;
  assign tctrl_wr = mwr && ofs == OFS_TCTRL && data_sram_wen[0];
  assign set_pend = t_en && timer == tcmp;
  always_comb
    mmio_rd = ofs == OFS_LED   ? {16'h0, led} :
              ofs == OFS_NUM   ? num :
              ofs == OFS_SW    ? {16'h0, switch_in} :
              ofs == OFS_TIMER ? timer :
              ofs == OFS_TCMP  ? tcmp :
              ofs == OFS_TCTRL ? {30'h0, pend, t_en} : 32'h0;
  // Requests in the reset cycle never reach the RAM
  data_sram_responder_bram_be #(.RAM_AW(RAM_AW)) u_ram (
    .clk  (clk),
    .we   ((rst && wr && !is_mmio) ? data_sram_wen : 4'b0),
    .re   (rst && rd && !is_mmio),
    .addr (data_sram_addr[RAM_AW+1:2]),
    .wdata(data_sram_wdata),
    .rdata(ram_q)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q  <= SEL_MMIO;
      mmio_q <= 32'h0;
      led    <= 16'h0;
      num    <= 32'h0;
      timer  <= 32'h0;
      tcmp   <= 32'h0;
      t_en   <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (rd) sel_q <= is_mmio ? SEL_MMIO : SEL_RAM;
      if (rd && is_mmio) mmio_q <= mmio_rd;
      if (mwr && ofs == OFS_LED)
        led <= {data_sram_wen[1] ? data_sram_wdata[15:8] : led[15:8],
                data_sram_wen[0] ? data_sram_wdata[7:0]  : led[7:0]};
      if (mwr && ofs == OFS_NUM) num <= lane_merge(num, data_sram_wdata, data_sram_wen);
      if (mwr && ofs == OFS_TCMP) tcmp <= lane_merge(tcmp, data_sram_wdata, data_sram_wen);
      timer <= (mwr && ofs == OFS_TIMER) ? lane_merge(timer, data_sram_wdata, data_sram_wen)
                                         : timer + {31'b0, t_en};
      if (tctrl_wr) t_en <= data_sram_wdata[TCTRL_EN];
      pend <= set_pend || (pend && !(tctrl_wr && data_sram_wdata[TCTRL_PEND]));
    end
  end
  assign data_sram_rdata = sel_q == SEL_MMIO ? mmio_q : ram_q;
  assign led_out   = led;
  assign num_out   = num;
  assign timer_irq = pend;
endmodule
